// File: rtl/ram_slave_pkg.sv
// ram_slave_pkg
// Shared definitions for the RAM handshake slave: default parameter values,
// the latency counter width, FSM state encodings and the access-type enum.
// Optional build macro used by the slave: RAM_SLAVE_RANGE_CHECK_EN.
package ram_slave_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 32;
    localparam int DEPTH_BYTES_DEF = 2048;
    localparam int LATENCY_DEF     = 1;

    // LATENCY runs 1..15, so LATENCY-1 always fits in 4 bits.
    localparam int CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/ram_byte_array.sv
// ram_byte_array
// Byte-wide storage with DATA_W/8 lanes. Lane k addresses base+k modulo
// DEPTH_BYTES, so a word access starting near the top wraps to byte 0.
// Reads are combinational; writes happen on clk when we_i is high, per lane
// qualified by be_i. Contents are never reset.
// Ports:
//   clk      in   clock
//   base_i   in   byte address of lane 0 (already reduced modulo depth)
//   we_i     in   write strobe
//   be_i     in   per-lane write enables
//   wdata_i  in   write data, lane k in bits [8k+7:8k]
//   rdata_o  out  read data, lane k in bits [8k+7:8k]
module ram_byte_array
    import ram_slave_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH_BYTES = DEPTH_BYTES_DEF
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_BYTES)-1:0] base_i,
    input  logic                           we_i,
    input  logic [DATA_W/8-1:0]            be_i,
    input  logic [DATA_W-1:0]              wdata_i,
    output logic [DATA_W-1:0]              rdata_o
);

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0]    mem_q [DEPTH_BYTES];
    logic [AW-1:0] lane_addr [NB];

    // Address arithmetic is done at AW bits so the carry out of the top
    // byte is simply dropped, giving the modulo wrap for free.
    always_comb begin
        for (int k = 0; k < NB; k++) begin
            lane_addr[k] = base_i + AW'(k);
            rdata_o[8*k +: 8] = mem_q[lane_addr[k]];
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < NB; k++) begin
                if (be_i[k]) begin
                    mem_q[lane_addr[k]] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ram_handshake_slave.sv
// ram_handshake_slave
// Level-request RAM slave with a fixed, parameterised response latency.
// A request sampled in IDLE is captured, held for LATENCY cycles and then
// committed on the same edge that raises the matching ack for one cycle.
// Requests seen outside IDLE are dropped. Write wins over read.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting; samples writeReq/readReq each edge
// WAIT  | access captured; latency counter running down to 0
// ACK   | ack high for this cycle; requests ignored; back to IDLE next
//
// Build macro: RAM_SLAVE_RANGE_CHECK_EN -- when defined, a word access that
// would run past DEPTH_BYTES raises addrErr with the ack, the write is
// dropped and read data is 0. When undefined, addresses wrap and addrErr
// is always 0.
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous reset, active low
//   readReq     in   read request (level)
//   writeReq    in   write request (level)
//   ramAddress  in   byte address (unaligned allowed)
//   ramOut      in   write data
//   byteEn      in   write lane enables
//   ramValue    out  read data, held until the next read commits
//   readAck     out  one-cycle read completion pulse
//   writeAck    out  one-cycle write completion pulse
//   busy        out  high whenever not IDLE
//   addrErr     out  range error, valid with the ack
module ram_handshake_slave
    import ram_slave_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH_BYTES = DEPTH_BYTES_DEF,
    parameter int LATENCY     = LATENCY_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                readReq,
    input  logic                writeReq,
    input  logic [ADDR_W-1:0]   ramAddress,
    input  logic [DATA_W-1:0]   ramOut,
    input  logic [DATA_W/8-1:0] byteEn,
    output logic [DATA_W-1:0]   ramValue,
    output logic                readAck,
    output logic                writeAck,
    output logic                busy,
    output logic                addrErr
);

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH_BYTES);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     be_q, be_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rack_q, rack_d;
    logic              wack_q, wack_d;
    logic              aerr_q, aerr_d;

    logic [DATA_W-1:0] mem_rdata;
    logic              commit;
    logic              mem_we;
    logic              range_err;

`ifdef RAM_SLAVE_RANGE_CHECK_EN
    // One extra bit so the last-byte address cannot overflow the compare.
    logic [ADDR_W:0] last_byte;
    assign last_byte = {1'b0, addr_q} + (ADDR_W+1)'(NB - 1);
    assign range_err = last_byte >= (ADDR_W+1)'(DEPTH_BYTES);
`else
    // Upper address bits only matter for the range check.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[ADDR_W-1:AW];
    assign range_err      = 1'b0;
`endif

    assign commit = (state_q == ST_WAIT) && (cnt_q == '0);
    // Gating with reset keeps a reset landing on the commit edge from
    // writing memory.
    assign mem_we = commit && (op_q == OP_WRITE) && !range_err && reset;

    ram_byte_array #(
        .DATA_W      (DATA_W),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_array (
        .clk     (clk),
        .base_i  (addr_q[AW-1:0]),
        .we_i    (mem_we),
        .be_i    (be_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        rack_d  = 1'b0;
        wack_d  = 1'b0;
        aerr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (writeReq) begin
                    op_d    = OP_WRITE;
                    addr_d  = ramAddress;
                    wdata_d = ramOut;
                    be_d    = byteEn;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end else if (readReq) begin
                    op_d    = OP_READ;
                    addr_d  = ramAddress;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    aerr_d  = range_err;
                    if (op_q == OP_WRITE) begin
                        wack_d = 1'b1;
                    end else begin
                        rack_d  = 1'b1;
                        rdata_d = range_err ? '0 : mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            rack_q  <= 1'b0;
            wack_q  <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            rack_q  <= rack_d;
            wack_q  <= wack_d;
            aerr_q  <= aerr_d;
        end
    end

    assign ramValue = rdata_q;
    assign readAck  = rack_q;
    assign writeAck = wack_q;
    assign addrErr  = aerr_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_handshake_slave.sv
// tb_ram_handshake_slave
// Three slaves (LATENCY 1, 4, 8) share one clock. A byte-array model per
// slave predicts read data, acks, busy and addrErr from the access rules.
module tb_ram_handshake_slave;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr [3];
    logic [31:0] wdat [3];
    logic [3:0]  be   [3];
    logic [31:0] rv   [3];
    logic [2:0]  rack;
    logic [2:0]  wack;
    logic [2:0]  busy;
    logic [2:0]  aerr;

    logic [7:0]  mem_m   [3][DEPTH];
    logic [31:0] last_rd [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ram_handshake_slave #(
            .DATA_W      (32),
            .ADDR_W      (32),
            .DEPTH_BYTES (DEPTH),
            .LATENCY     (g == 0 ? 1 : (g == 1 ? 4 : 8))
        ) u_dut (
            .clk        (clk),
            .reset      (rst_n[g]),
            .readReq    (rd[g]),
            .writeReq   (wr[g]),
            .ramAddress (addr[g]),
            .ramOut     (wdat[g]),
            .byteEn     (be[g]),
            .ramValue   (rv[g]),
            .readAck    (rack[g]),
            .writeAck   (wack[g]),
            .busy       (busy[g]),
            .addrErr    (aerr[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
    endfunction

    function automatic bit range_bad(input logic [31:0] a);
`ifdef RAM_SLAVE_RANGE_CHECK_EN
        return (longint'(a) + 3 >= DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    // One access on slave i, started just after an active edge; checks
    // every edge up to and including the return to IDLE.
    task automatic run_access(input int i, input bit w, input bit r,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, input string tag);
        bit is_wr = w;
        bit is_rd = r && !w;
        bit err   = range_bad(a);
        int lat   = lat_of(i);
        logic [31:0] exp_rd;
        if (is_wr && !err) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) mem_m[i][(a + k) % DEPTH] = d[8*k +: 8];
        end
        if (is_rd) begin
            for (int k = 0; k < 4; k++)
                exp_rd[8*k +: 8] = mem_m[i][(a + k) % DEPTH];
            if (err) exp_rd = '0;
            last_rd[i] = exp_rd;
        end
        rd[i] = r; wr[i] = w; addr[i] = a; wdat[i] = d; be[i] = b;
        @(posedge clk); #1;
        rd[i] = 1'b0; wr[i] = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(posedge clk); #1;
            total++;
            if (rack[i] !== (is_rd && c == lat)) begin
                bad++;
                $display("FAIL %s readAck dut%0d edge+%0d: got %b want %b", tag, i, c, rack[i], is_rd && c == lat);
            end
            total++;
            if (wack[i] !== (is_wr && c == lat)) begin
                bad++;
                $display("FAIL %s writeAck dut%0d edge+%0d: got %b want %b", tag, i, c, wack[i], is_wr && c == lat);
            end
            total++;
            if (busy[i] !== (c <= lat)) begin
                bad++;
                $display("FAIL %s busy dut%0d edge+%0d: got %b want %b", tag, i, c, busy[i], c <= lat);
            end
            total++;
            if (aerr[i] !== (err && c == lat)) begin
                bad++;
                $display("FAIL %s addrErr dut%0d edge+%0d: got %b want %b", tag, i, c, aerr[i], err && c == lat);
            end
            if (c >= lat) begin
                total++;
                if (rv[i] !== last_rd[i]) begin
                    bad++;
                    $display("FAIL %s ramValue dut%0d edge+%0d: got %h want %h", tag, i, c, rv[i], last_rd[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 3'b000; rd = 3'b000; wr = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wdat[i] = '0; be[i] = '0; last_rd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({busy[i], rack[i], wack[i], aerr[i]} !== 4'b0000) begin
                bad++;
                $display("FAIL reset flags dut%0d: got %b want 0000", i, {busy[i], rack[i], wack[i], aerr[i]});
            end
            total++;
            if (rv[i] !== 32'h0) begin
                bad++;
                $display("FAIL reset ramValue dut%0d: got %h want 0", i, rv[i]);
            end
        end
        rst_n = 3'b111;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < DEPTH; a += 4)
                run_access(i, 1'b1, 1'b0, 32'(a), $urandom, 4'hF, "fill");
    endtask

    task automatic test_basic();
        run_access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, "basic_wr");
        run_access(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, "basic_rd");
        total++;
        if (rv[0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL basic readback: got %h want deadbeef", rv[0]);
        end
    endtask

    task automatic test_latency();
        run_access(1, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, "lat4_rd");
        run_access(2, 1'b0, 1'b1, 32'h24, 32'h0, 4'h0, "lat8_rd");
    endtask

    task automatic test_byte_enable();
        run_access(0, 1'b1, 1'b0, 32'h30, 32'h11223344, 4'hF, "be_prefill");
        run_access(0, 1'b1, 1'b0, 32'h30, 32'hAABBCCDD, 4'h5, "be_wr");
        run_access(0, 1'b0, 1'b1, 32'h30, 32'h0, 4'h0, "be_rd");
        total++;
        if (rv[0] !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL byte_enable readback: got %h want 11bb33dd", rv[0]);
        end
        run_access(1, 1'b1, 1'b0, 32'h34, 32'h55667788, 4'h0, "be_none");
    endtask

    task automatic test_both_high();
        run_access(0, 1'b1, 1'b1, 32'h40, 32'h01020304, 4'hF, "both_wr");
        run_access(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, "both_rd");
        total++;
        if (rv[0] !== 32'h01020304) begin
            bad++;
            $display("FAIL both_high readback: got %h want 01020304", rv[0]);
        end
    endtask

    task automatic test_wrap();
        run_access(0, 1'b1, 1'b0, 32'h7FE, 32'hCAFEF00D, 4'hF, "wrap_wr");
        run_access(0, 1'b0, 1'b1, 32'h7FC, 32'h0, 4'h0, "wrap_rd_top");
`ifndef RAM_SLAVE_RANGE_CHECK_EN
        total++;
        if (rv[0][31:16] !== 16'hF00D) begin
            bad++;
            $display("FAIL wrap top bytes: got %h want f00d", rv[0][31:16]);
        end
`endif
        run_access(0, 1'b0, 1'b1, 32'h000, 32'h0, 4'h0, "wrap_rd_bot");
`ifndef RAM_SLAVE_RANGE_CHECK_EN
        total++;
        if (rv[0][15:0] !== 16'hCAFE) begin
            bad++;
            $display("FAIL wrap bottom bytes: got %h want cafe", rv[0][15:0]);
        end
`endif
        run_access(0, 1'b0, 1'b1, 32'h7FE, 32'h0, 4'h0, "wrap_rd_err");
    endtask

    // A write request raised only while slave 1 is busy must be dropped.
    task automatic test_ignore();
        int lat = lat_of(1);
        rd[1] = 1'b1; addr[1] = 32'h50;
        @(posedge clk); #1;
        rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h60; wdat[1] = 32'hFFFFFFFF; be[1] = 4'hF;
        for (int c = 1; c <= lat + 4; c++) begin
            @(posedge clk); #1;
            if (c == lat) wr[1] = 1'b0;
            total++;
            if (wack[1] !== 1'b0) begin
                bad++;
                $display("FAIL ignore writeAck edge+%0d: got %b want 0", c, wack[1]);
            end
        end
        for (int k = 0; k < 4; k++) last_rd[1][8*k +: 8] = mem_m[1][32'h50 + k];
        total++;
        if (rv[1] !== last_rd[1]) begin
            bad++;
            $display("FAIL ignore readback: got %h want %h", rv[1], last_rd[1]);
        end
        run_access(1, 1'b0, 1'b1, 32'h60, 32'h0, 4'h0, "ignore_rd");
    endtask

    task automatic test_reset_abort();
        logic [31:0] orig;
        for (int k = 0; k < 4; k++) orig[8*k +: 8] = mem_m[2][32'h100 + k];
        wr[2] = 1'b1; addr[2] = 32'h100; wdat[2] = ~orig; be[2] = 4'hF;
        @(posedge clk); #1;
        wr[2] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n[2] = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy[2], wack[2], aerr[2]} !== 3'b000) begin
            bad++;
            $display("FAIL abort flags: got %b want 000", {busy[2], wack[2], aerr[2]});
        end
        total++;
        if (rv[2] !== 32'h0) begin
            bad++;
            $display("FAIL abort ramValue: got %h want 0", rv[2]);
        end
        rst_n[2] = 1'b1;
        last_rd[2] = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if (wack[2] !== 1'b0 || busy[2] !== 1'b0) begin
                bad++;
                $display("FAIL abort late ack c%0d: got wack=%b busy=%b want 0 0", c, wack[2], busy[2]);
            end
        end
        run_access(2, 1'b0, 1'b1, 32'h100, 32'h0, 4'h0, "abort_rd");
        total++;
        if (rv[2] !== orig) begin
            bad++;
            $display("FAIL abort memory: got %h want %h", rv[2], orig);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int i = int'($urandom_range(0, 2));
            bit w = 1'($urandom_range(0, 1));
            bit r = 1'($urandom_range(0, 1));
            logic [31:0] a;
            if (!w && !r) r = 1'b1;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(2040, 2100));
            else a = 32'($urandom_range(0, 2047));
            run_access(i, w, r, a, $urandom, 4'($urandom_range(0, 15)), "random");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_latency();
        test_byte_enable();
        test_both_high();
        test_wrap();
        test_ignore();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
